rr_grant_responder: RTL and testbench
=====================================

Name: rr_grant_responder

Overview:
Resource-side counterpart of the team's round-robin arbiter. It consumes the arbiter's one-hot grant vector and locks ownership of the shared downstream port to the granted requester. It then forwards that requester's data beats with a valid/ready handshake for up to MAX_BEATS beats, and finally pulses a per-requester done back to the owner. Grant activity outside IDLE is ignored, so the arbiter's per-cycle rotation cannot break a burst in progress.

Parameters:
N, 7, number of requesters; must match the arbiter's N.
W, 8, data width per requester.
MAX_BEATS, 4, maximum beats per ownership; must be at least 1.
IDW, $clog2(N), width of owner_id; this is a localparam.

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst  in  1  asynchronous reset, active-low: asserted when 0, deasserted synchronously by the environment.
grant  in  N  one-hot grant from the arbiter.
req  in  N  request lines; req[i] doubles as the beat-valid for requester i.
in_data  in  N*W  packed requester data; slice i is [i*W +: W].
in_last  in  N  requester i marks its final beat.
in_ready  out  N  beat-accept strobe to the owner only.
out_valid  out  1  downstream beat valid.
out_data  out  W  downstream beat data.
out_last  out  1  final beat of the ownership.
out_ready  in  1  downstream ready.
owner_id  out  IDW  binary index of the current owner.
busy  out  1  high in XFER and DONE.
done  out  N  one-cycle pulse to the owner when ownership ends.
aborted  out  1  one-cycle pulse, concurrent with done, when the owner withdrew early.
err_multi_grant  out  1  sticky flag: a multi-hot grant was seen in IDLE.

Behaviour:
- Reset (rst=0): asynchronously forces state=IDLE. All outputs go to 0, including owner_id, beat_cnt and err_multi_grant. A reset during XFER drops out_valid and in_ready immediately; the partial burst is lost and no done is issued.
- FSM states: IDLE, XFER, DONE.
- IDLE:
  - grant has exactly one bit set and (grant & req) != 0: latch owner_oh=grant, owner_id=encode(grant), beat_cnt=0, go to XFER. The first out_valid can appear on the cycle after the grant, so capture latency is 1 cycle.
  - grant multi-hot: set err_multi_grant, capture nothing, stay in IDLE.
  - grant==0, or the granted line is not requesting: stay in IDLE.
- XFER (combinational outputs from owner state):
  - out_valid = req[owner]; out_data = in_data slice of owner (0 when out_valid=0).
  - in_ready[owner] = out_ready; all other in_ready bits are 0.
  - Beat accepted when req[owner] & out_ready.
  - out_last = out_valid & (in_last[owner] | beat_cnt==MAX_BEATS-1).
  - Accepted beat with out_last=1: go to DONE.
  - Accepted beat with out_last=0: beat_cnt++. beat_cnt is IDW-independent and sized $clog2(MAX_BEATS+1); it never wraps.
  - req[owner]=0 with no beat accepted: owner withdrew; go to DONE with aborted pending. A stall (req=1, out_ready=0) is not an abort.
  - grant is ignored entirely in this state.
- DONE (exactly 1 cycle): done[owner]=1, aborted=1 if the burst was withdrawn, out_valid=0. Then go to IDLE; owner_id holds its value until the next capture.
- Back-to-back: a grant present in the IDLE cycle after DONE is captured normally. Minimum gap between two bursts is 1 DONE cycle plus 1 IDLE cycle.
- MAX_BEATS=1: every accepted beat carries out_last=1.
- err_multi_grant clears only on reset.

Test Plan:
- N=7, W=8, MAX_BEATS=4. grant=0000100, req[2]=1 with data 0x11,0x22,0x33,0x44, in_last never set, out_ready=1 -> owner_id=2. Four beats on consecutive cycles; out_last on 0x44; done=0000100 for one cycle; busy falls after DONE.
- Owner 5 sends 2 beats with in_last on beat 2 (0xA0, 0xA1) while out_ready toggles 1,0,1 -> out_valid held high through the stall, data is stable while stalled, out_last on 0xA1, done[5] pulses once, aborted=0.
- Owner 0 sends 1 beat, then req[0] drops in XFER -> DONE next cycle, done[0]=1 and aborted=1, no out_last seen.
- grant=0000011 in IDLE -> err_multi_grant=1 and stays set; state remains IDLE; out_valid=0. Then grant=0000001 -> normal capture while the error flag stays 1.
- grant rotates every cycle during owner 3's burst -> owner_id stays 3, all 4 beats come from slice 3, in_ready only ever asserts bit 3.
- rst driven low mid-burst after beat 2 -> out_valid, in_ready, busy and done are 0 immediately. After release, state=IDLE and a new grant is captured normally.

Source files
------------

// File: rtl/rr_grant_responder.sv
// rr_grant_responder: locks the shared downstream port to a single granted
// requester, forwards its burst over valid/ready, then pulses done back.
module rr_grant_responder #(
   parameter  int N         = 7,
   parameter  int W         = 8,
   parameter  int MAX_BEATS = 4,
   localparam int IDW       = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   grant,
   input  logic [N-1:0]   req,
   input  logic [N*W-1:0] in_data,
   input  logic [N-1:0]   in_last,
   output logic [N-1:0]   in_ready,
   output logic           out_valid,
   output logic [W-1:0]   out_data,
   output logic           out_last,
   input  logic           out_ready,
   output logic [IDW-1:0] owner_id,
   output logic           busy,
   output logic [N-1:0]   done,
   output logic           aborted,
   output logic           err_multi_grant
);

   localparam int CW = $clog2(MAX_BEATS + 1);

   typedef enum logic [1:0] {
      IDLE,
      XFER,
      DONE
   } state_t;

   state_t         state_q;
   logic [N-1:0]   owner_oh_q;
   logic [IDW-1:0] owner_id_q;
   logic [CW-1:0]  cnt_q;
   logic           abort_q;
   logic           err_q;

   logic           grant_one;
   logic           grant_multi;
   logic           own_req;
   logic           own_last;
   logic           accept;
   logic [W-1:0]   own_data;
   logic [IDW-1:0] grant_id;

   always_comb begin
      own_data = '0;
      grant_id = '0;
      for (int i = 0; i < N; i++) begin
         if (owner_oh_q[i]) own_data = in_data[i*W +: W];
         if (grant[i]) grant_id = IDW'(i);
      end
   end

   // A value is one-hot when it is nonzero and clearing its lowest set bit leaves zero.
   assign grant_one   = (grant != '0) && ((grant & (grant - N'(1))) == '0);
   assign grant_multi = (grant != '0) && !grant_one;

   assign own_req   = |(req & owner_oh_q);
   assign own_last  = |(in_last & owner_oh_q);
   assign out_valid = (state_q == XFER) && own_req;
   assign out_data  = out_valid ? own_data : '0;
   assign out_last  = out_valid &&
                      (own_last || cnt_q == CW'(MAX_BEATS - 1));
   assign accept    = out_valid && out_ready;

   assign in_ready = (state_q == XFER && out_ready) ? owner_oh_q : '0;
   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE) ? owner_oh_q : '0;
   assign aborted  = (state_q == DONE) && abort_q;

   assign owner_id        = owner_id_q;
   assign err_multi_grant = err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         owner_oh_q <= '0;
         owner_id_q <= '0;
         cnt_q      <= '0;
         abort_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               abort_q <= 1'b0;
               if (grant_multi) begin
                  err_q <= 1'b1;
               end else if (grant_one && |(grant & req)) begin
                  state_q    <= XFER;
                  owner_oh_q <= grant;
                  owner_id_q <= grant_id;
                  cnt_q      <= '0;
               end
            end
            XFER: begin
               if (accept) begin
                  if (out_last) state_q <= DONE;
                  else          cnt_q   <= cnt_q + CW'(1);
               end else if (!own_req) begin
                  state_q <= DONE;
                  abort_q <= 1'b1;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rr_grant_responder.sv
// tb_rr_grant_responder: scoreboard bench; a burst-level model predicts the
// downstream beats and done/aborted pulses, a monitor checks them as they occur.
module tb_rr_grant_responder;

   localparam int N   = 7;
   localparam int W   = 8;
   localparam int MB  = 4;
   localparam int IDW = $clog2(N);

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   grant;
   logic [N-1:0]   req;
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_last;
   logic [N-1:0]   in_ready;
   logic           out_valid;
   logic [W-1:0]   out_data;
   logic           out_last;
   logic           out_ready;
   logic [IDW-1:0] owner_id;
   logic           busy;
   logic [N-1:0]   done;
   logic           aborted;
   logic           err;

   typedef struct packed {
      logic [W-1:0] d;
      logic         l;
   } beat_t;

   beat_t exp_b[$];
   int    exp_o[$];
   bit    exp_a[$];
   int    n_chk     = 0;
   int    n_fail    = 0;
   int    cur_owner = 0;

   rr_grant_responder #(.N(N), .W(W), .MAX_BEATS(MB)) dut (
      .clk             (clk),
      .rst             (rst),
      .grant           (grant),
      .req             (req),
      .in_data         (in_data),
      .in_last         (in_last),
      .in_ready        (in_ready),
      .out_valid       (out_valid),
      .out_data        (out_data),
      .out_last        (out_last),
      .out_ready       (out_ready),
      .owner_id        (owner_id),
      .busy            (busy),
      .done            (done),
      .aborted         (aborted),
      .err_multi_grant (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   task automatic flag(input string nm);
      n_chk++;
      n_fail++;
      $display("FAIL %s: got event, expected none at %0t", nm, $time);
   endtask

   task automatic monitor();
      logic         pv;
      logic [W-1:0] pd;
      beat_t        b;
      int           o;
      bit           a;
      pv = 1'b0;
      pd = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            pv = 1'b0;
            continue;
         end
         if (pv) begin
            chk("stall_valid_held", out_valid, 1);
            chk("stall_data_stable", out_data, pd);
         end
         pv = out_valid && !out_ready;
         pd = out_data;
         if (in_ready != '0)
            chk("in_ready_owner_only", in_ready, N'(1) << cur_owner);
         if (out_valid && out_ready) begin
            if (exp_b.size() == 0) begin
               flag("unexpected_beat");
            end else begin
               b = exp_b.pop_front();
               chk("beat_data", out_data, b.d);
               chk("beat_last", out_last, b.l);
            end
         end
         if (done != '0) begin
            if (exp_o.size() == 0) begin
               flag("unexpected_done");
            end else begin
               o = exp_o.pop_front();
               a = exp_a.pop_front();
               chk("done_vec", done, N'(1) << o);
               chk("aborted", aborted, a);
               chk("owner_id_at_done", owner_id, o);
            end
         end else begin
            chk("aborted_without_done", aborted, 0);
         end
      end
   endtask

   task automatic drive(input int o, input bit v, input logic [W-1:0] dat,
                        input bit lst, input logic [N-1:0] g,
                        input bit stall);
      for (int i = 0; i < N; i++) in_data[i*W +: W] = W'($urandom);
      req              = N'($urandom);
      in_last          = N'($urandom);
      req[o]           = v;
      in_data[o*W +: W] = dat;
      in_last[o]       = lst;
      grant            = g;
      out_ready        = stall ? 1'($urandom % 2) : 1'b1;
   endtask

   // Model: the owner's beats flow until one carries in_last or MB beats have
   // gone; if the requester runs dry first the ownership ends aborted.
   task automatic burst(input int o, input int L, input int lastidx,
                        input int base, input int step, input bit stall,
                        input bit rot, input int rst_after);
      logic [W-1:0] d[8];
      beat_t        b;
      int           s;
      int           nb;
      int           idx;
      bit           ab;
      bit           fin;
      bit           acc;
      for (int i = 0; i < 8; i++)
         d[i] = (base >= 0) ? W'(base + i * step) : W'($urandom);
      s  = (lastidx >= 0 && lastidx < MB - 1) ? lastidx : MB - 1;
      ab = (s >= L);
      nb = ab ? L : s + 1;
      if (rst_after >= 0) nb = rst_after;
      for (int i = 0; i < nb; i++) begin
         b.d = d[i];
         b.l = (i == s);
         exp_b.push_back(b);
      end
      if (rst_after < 0) begin
         exp_o.push_back(o);
         exp_a.push_back(ab);
      end
      @(posedge clk);
      #1;
      cur_owner = o;
      drive(o, 1'b1, d[0], lastidx == 0, N'(1) << o, stall);
      idx = 0;
      fin = 1'b0;
      for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
         @(negedge clk);
         if (cyc == 0) chk("idle_at_grant", busy, 0);
         if (cyc == 1) begin
            chk("capture_owner_id", owner_id, o);
            chk("first_valid_after_grant", out_valid, 1);
         end
         acc = in_ready[o] && req[o];
         fin = (done != '0);
         @(posedge clk);
         #1;
         if (acc) idx++;
         if (fin) begin
            grant   = '0;
            req     = '0;
            in_last = '0;
         end else if (rst_after >= 0 && idx == rst_after) begin
            rst = 1'b0;
            #1;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_owner_id", owner_id, 0);
            grant = '0;
            req   = '0;
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b1;
            fin = 1'b1;
         end else begin
            drive(o, idx < L, d[idx], idx == lastidx,
                  rot ? N'(1) << ((o + cyc + 1) % N) : '0, stall);
         end
      end
      if (!fin) begin
         n_chk++;
         n_fail++;
         $display("FAIL burst_timeout: got no done, expected done for owner %0d", o);
      end else if (rst_after < 0) begin
         @(negedge clk);
         chk("busy_after_done", busy, 0);
      end
   endtask

   initial begin
      rst       = 1'b1;
      grant     = '0;
      req       = '0;
      in_data   = '0;
      in_last   = '0;
      out_ready = 1'b0;
      #2 rst = 1'b0;
      #2;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_last", out_last, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_in_ready", in_ready, 0);
      chk("reset_owner_id", owner_id, 0);
      chk("reset_err", err, 0);
      chk("reset_aborted", aborted, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      fork
         monitor();
      join_none

      burst(2, 4, -1, 'h11, 'h11, 1'b0, 1'b0, -1);
      burst(5, 2, 1, 'hA0, 1, 1'b1, 1'b0, -1);
      burst(0, 1, -1, 'h5A, 0, 1'b0, 1'b0, -1);

      @(posedge clk);
      #1;
      grant = N'(3);
      req   = N'(3);
      @(posedge clk);
      #1;
      grant = '0;
      req   = '0;
      @(negedge clk);
      chk("multi_grant_err", err, 1);
      chk("multi_grant_idle", busy, 0);
      chk("multi_grant_no_valid", out_valid, 0);
      repeat (3) @(negedge clk);
      chk("err_sticky", err, 1);
      burst(0, 3, -1, 'h70, 3, 1'b1, 1'b0, -1);
      chk("err_sticky_after_burst", err, 1);

      burst(3, 4, -1, 'h30, 1, 1'b0, 1'b1, -1);
      burst(4, 4, -1, 'h40, 1, 1'b0, 1'b0, 2);
      @(negedge clk);
      chk("err_cleared_by_reset", err, 0);
      chk("idle_after_reset", busy, 0);
      burst(6, 6, -1, 'hC0, 1, 1'b0, 1'b0, -1);

      for (int k = 0; k < 60; k++)
         burst($urandom % N, $urandom_range(1, 6),
               int'($urandom_range(0, 6)) - 1, -1, 0,
               1'($urandom % 2), 1'($urandom % 2), -1);

      repeat (4) @(negedge clk);
      chk("beats_left", exp_b.size(), 0);
      chk("dones_left", exp_o.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
